// File: rtl/ex_muldiv_stage_if.sv
// Execute-stage bus: ID/EX inputs, EX/MEM register outputs and the upstream stall request.
interface ex_muldiv_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 2
);
  logic                 iStall;
  logic                 iFlush;
  logic                 iValid;
  logic [2:0]           iFunc3;
  logic [6:0]           iFunc7;
  logic                 iImmEn;
  logic [XLEN-1:0]      iImm;
  logic [XLEN-1:0]      iRs1;
  logic [XLEN-1:0]      iRs2;
  logic [4:0]           iRdAddr;
  logic [NFWD-1:0]      iFwS1Sel;
  logic [NFWD-1:0]      iFwS2Sel;
  logic [NFWD*XLEN-1:0] iFwData;
  logic                 oValid;
  logic [4:0]           oRdAddr;
  logic [XLEN-1:0]      oResult;
  logic [XLEN-1:0]      oStore;
  logic [2:0]           oFunc3;
  logic                 oBusy;

  modport master (
    output iStall, iFlush, iValid, iFunc3, iFunc7, iImmEn, iImm, iRs1, iRs2,
           iRdAddr, iFwS1Sel, iFwS2Sel, iFwData,
    input  oValid, oRdAddr, oResult, oStore, oFunc3, oBusy
  );

  modport slave (
    input  iStall, iFlush, iValid, iFunc3, iFunc7, iImmEn, iImm, iRs1, iRs2,
           iRdAddr, iFwS1Sel, iFwS2Sel, iFwData,
    output oValid, oRdAddr, oResult, oStore, oFunc3, oBusy
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU plus iterative RV32M multiply/divide with stall handshake.
module ex_muldiv_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NFWD  = 2,
  parameter int unsigned STEPS = 1
) (
  input logic             iClk,
  input logic             nRst,
  ex_muldiv_stage_if.slave bus
);
  localparam int unsigned NITER = XLEN / STEPS;
  localparam int unsigned CW    = $clog2(NITER + 1);
  localparam int unsigned SHW   = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, b_reg, c_store;
  logic [2:0]      c_func3;
  logic [4:0]      c_rd;
  logic            c_valid, c_neg_p, c_neg_r, c_special;

  logic [XLEN-1:0] op_a, fw_b, op_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic            m_op, a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  // Walk from the highest index down so the lowest set bit wins.
  always_comb begin
    op_a = bus.iRs1;
    fw_b = bus.iRs2;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (bus.iFwS1Sel[NFWD-1-i]) op_a = bus.iFwData[(NFWD-1-i)*XLEN +: XLEN];
      if (bus.iFwS2Sel[NFWD-1-i]) fw_b = bus.iFwData[(NFWD-1-i)*XLEN +: XLEN];
    end
    op_b = bus.iImmEn ? bus.iImm : fw_b;
  end

  assign m_op  = bus.iValid & (bus.iFunc7 == 7'b0000001) & !bus.iImmEn;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.iFunc3)
      3'd0: alu_res = (!bus.iImmEn && bus.iFunc7[5]) ? op_a - op_b : op_a + op_b;
      3'd1: alu_res = op_a << shamt;
      3'd2: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      3'd3: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      3'd4: alu_res = op_a ^ op_b;
      3'd5: begin
        if (bus.iFunc7[5]) alu_res = $signed(op_a) >>> shamt;
        else               alu_res = op_a >> shamt;
      end
      3'd6: alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  // Sign handling: the core only ever sees magnitudes; signs are reapplied on the way out.
  assign a_sgn    = (bus.iFunc3 == 3'd1) | (bus.iFunc3 == 3'd2) | (bus.iFunc3 == 3'd4) | (bus.iFunc3 == 3'd6);
  assign b_sgn    = (bus.iFunc3 == 3'd1) | (bus.iFunc3 == 3'd4) | (bus.iFunc3 == 3'd6);
  assign a_neg    = a_sgn & op_a[XLEN-1];
  assign b_neg    = b_sgn & op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;
  assign div0     = bus.iFunc3[2] & (op_b == '0);
  assign ovf      = bus.iFunc3[2] & b_sgn & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  assign spec_res = div0 ? (bus.iFunc3[1] ? op_a : '1) : (bus.iFunc3[1] ? '0 : op_a);

  logic [XLEN-1:0] nhi, nlo, diff;
  logic [XLEN:0]   shifted, sum;

  always_comb begin
    nhi     = hi;
    nlo     = lo;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    for (int unsigned s = 0; s < STEPS; s++) begin
      if (c_func3[2]) begin
        shifted = {nhi, nlo[XLEN-1]};
        // Partial remainder stays below the divisor, so the low XLEN bits of the difference are exact.
        diff = shifted[XLEN-1:0] - b_reg;
        if (shifted >= {1'b0, b_reg}) begin
          nhi = diff;
          nlo = {nlo[XLEN-2:0], 1'b1};
        end else begin
          nhi = shifted[XLEN-1:0];
          nlo = {nlo[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, nhi} + (nlo[0] ? {1'b0, b_reg} : '0);
        nlo = {sum[0], nlo[XLEN-1:1]};
        nhi = sum[XLEN:1];
      end
    end
  end

  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   quot, rem, md_res;

  always_comb begin
    prod_n = c_neg_p ? -{hi, lo} : {hi, lo};
    quot   = c_neg_p ? -lo : lo;
    rem    = c_neg_r ? -hi : hi;
    if (c_special)          md_res = lo;
    else if (c_func3[2])    md_res = c_func3[1] ? rem : quot;
    else if (c_func3 == '0) md_res = prod_n[XLEN-1:0];
    else                    md_res = prod_n[2*XLEN-1:XLEN];
  end

  assign bus.oBusy = ((state == IDLE) & m_op) | (state == BUSY) | ((state == DONE) & bus.iStall);

  always_ff @(posedge iClk) begin
    if (!nRst || bus.iFlush) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      b_reg       <= '0;
      c_store     <= '0;
      c_func3     <= '0;
      c_rd        <= '0;
      c_valid     <= 1'b0;
      c_neg_p     <= 1'b0;
      c_neg_r     <= 1'b0;
      c_special   <= 1'b0;
      bus.oValid  <= 1'b0;
      bus.oRdAddr <= '0;
      bus.oResult <= '0;
      bus.oStore  <= '0;
      bus.oFunc3  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_op) begin
            state     <= (div0 | ovf) ? DONE : BUSY;
            cnt       <= CW'(NITER);
            hi        <= '0;
            lo        <= (div0 | ovf) ? spec_res : a_mag;
            b_reg     <= b_mag;
            c_store   <= fw_b;
            c_func3   <= bus.iFunc3;
            c_rd      <= bus.iRdAddr;
            c_valid   <= bus.iValid;
            c_neg_p   <= a_neg ^ b_neg;
            c_neg_r   <= a_neg;
            c_special <= div0 | ovf;
          end
        end
        BUSY: begin
          hi  <= nhi;
          lo  <= nlo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        default: begin
          if (!bus.iStall) state <= IDLE;
        end
      endcase

      if (!bus.iStall) begin
        if (((state == IDLE) && m_op) || (state == BUSY)) begin
          bus.oValid <= 1'b0;
        end else if (state == DONE) begin
          bus.oValid  <= c_valid;
          bus.oRdAddr <= c_rd;
          bus.oResult <= md_res;
          bus.oStore  <= c_store;
          bus.oFunc3  <= c_func3;
        end else begin
          bus.oValid  <= bus.iValid;
          bus.oRdAddr <= bus.iRdAddr;
          bus.oResult <= alu_res;
          bus.oStore  <= fw_b;
          bus.oFunc3  <= bus.iFunc3;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed bench for ex_muldiv_stage (XLEN=32, NFWD=2, STEPS=1).
module tb_ex_muldiv_stage;
  logic clk;
  logic nrst;
  int   tests;
  int   fails;

  ex_muldiv_stage_if #(.XLEN(32), .NFWD(2)) bus ();

  ex_muldiv_stage #(.XLEN(32), .NFWD(2), .STEPS(1)) dut (
    .iClk (clk),
    .nRst (nrst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                       input logic immen, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [31:0] exp_res, input logic [31:0] exp_store,
                       input int exp_edges, input int exp_busy);
    int edges;
    int busyc;
    bus.iFunc3   = f3;
    bus.iFunc7   = f7;
    bus.iImmEn   = immen;
    bus.iImm     = imm;
    bus.iRs1     = rs1;
    bus.iRs2     = rs2;
    bus.iFwS1Sel = s1;
    bus.iFwS2Sel = s2;
    bus.iRdAddr  = 5'd9;
    bus.iValid   = 1'b1;
    #1;
    edges = 0;
    busyc = 0;
    while (!bus.oValid && edges < 200) begin
      if (bus.oBusy) busyc++;
      tick();
      edges++;
    end
    bus.iValid = 1'b0;
    check({tag, "_res"}, bus.oResult, exp_res);
    check({tag, "_store"}, bus.oStore, exp_store);
    check({tag, "_rd"}, {27'd0, bus.oRdAddr}, 32'd9);
    check({tag, "_edges"}, edges, exp_edges);
    check({tag, "_busy"}, busyc, exp_busy);
    tick();
    check({tag, "_pulse"}, {31'd0, bus.oValid}, 32'd0);
  endtask

  initial begin
    int seen;
    tests = 0;
    fails = 0;
    nrst         = 1'b0;
    bus.iStall   = 1'b0;
    bus.iFlush   = 1'b0;
    bus.iValid   = 1'b0;
    bus.iFunc3   = '0;
    bus.iFunc7   = '0;
    bus.iImmEn   = 1'b0;
    bus.iImm     = '0;
    bus.iRs1     = '0;
    bus.iRs2     = '0;
    bus.iRdAddr  = '0;
    bus.iFwS1Sel = '0;
    bus.iFwS2Sel = '0;
    bus.iFwData  = {32'd200, 32'd100};
    tick();
    tick();
    check("rst_valid", {31'd0, bus.oValid}, 32'd0);
    check("rst_result", bus.oResult, 32'd0);
    check("rst_busy", {31'd0, bus.oBusy}, 32'd0);
    nrst = 1'b1;
    tick();

    do_op("add_fw", 3'd0, 7'h00, 1'b0, 32'd0, 32'd5, 32'd7, 2'b01, 2'b00, 32'd107, 32'd7, 1, 0);
    do_op("sub_prio", 3'd0, 7'h20, 1'b0, 32'd0, 32'd0, 32'd3, 2'b10, 2'b11, 32'd100, 32'd100, 1, 0);
    do_op("imm_not_m", 3'd0, 7'h01, 1'b1, 32'd3, 32'd5, 32'd9, 2'b00, 2'b00, 32'd8, 32'd9, 1, 0);
    do_op("mul", 3'd0, 7'h01, 1'b0, 32'd0, -32'sd3, 32'd7, 2'b00, 2'b00, 32'hFFFFFFEB, 32'd7, 34, 33);
    do_op("mulh", 3'd1, 7'h01, 1'b0, 32'd0, -32'sd3, 32'd7, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd7, 34, 33);
    do_op("mulhsu", 3'd2, 7'h01, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd2, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd2, 34, 33);
    do_op("mulhu", 3'd3, 7'h01, 1'b0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFF, 34, 33);
    do_op("div_by0", 3'd4, 7'h01, 1'b0, 32'd0, 32'd7, 32'd0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd0, 2, 1);
    do_op("remu_by0", 3'd7, 7'h01, 1'b0, 32'd0, 32'd7, 32'd0, 2'b00, 2'b00, 32'd7, 32'd0, 2, 1);
    do_op("div_ovf", 3'd4, 7'h01, 1'b0, 32'd0, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 2, 1);
    do_op("rem_ovf", 3'd6, 7'h01, 1'b0, 32'd0, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 32'd0, 32'hFFFFFFFF, 2, 1);
    do_op("rem_neg", 3'd6, 7'h01, 1'b0, 32'd0, -32'sd7, 32'd2, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd2, 34, 33);
    do_op("div_neg", 3'd4, 7'h01, 1'b0, 32'd0, -32'sd7, 32'd2, 2'b00, 2'b00, 32'hFFFFFFFD, 32'd2, 34, 33);
    do_op("divu", 3'd5, 7'h01, 1'b0, 32'd0, 32'd100, 32'd7, 2'b00, 2'b00, 32'd14, 32'd7, 34, 33);
    do_op("remu", 3'd7, 7'h01, 1'b0, 32'd0, 32'd100, 32'd7, 2'b00, 2'b00, 32'd2, 32'd7, 34, 33);

    // Stall while the multiply sits in DONE.
    bus.iFunc3 = 3'd0; bus.iFunc7 = 7'h01; bus.iImmEn = 1'b0;
    bus.iRs1 = 32'd6; bus.iRs2 = 32'd7; bus.iFwS1Sel = '0; bus.iFwS2Sel = '0;
    bus.iValid = 1'b1;
    #1;
    repeat (33) tick();
    check("done_nobusy", {31'd0, bus.oBusy}, 32'd0);
    bus.iStall = 1'b1;
    #1;
    check("stall_busy", {31'd0, bus.oBusy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_valid", {31'd0, bus.oValid}, 32'd0);
      check("stall_hold_busy", {31'd0, bus.oBusy}, 32'd1);
    end
    bus.iStall = 1'b0;
    #1;
    check("unstall_busy", {31'd0, bus.oBusy}, 32'd0);
    tick();
    bus.iValid = 1'b0;
    check("unstall_valid", {31'd0, bus.oValid}, 32'd1);
    check("unstall_res", bus.oResult, 32'd42);
    tick();
    check("unstall_pulse", {31'd0, bus.oValid}, 32'd0);

    // Stall holds a valid ALU result; flush beats stall.
    bus.iFunc7 = 7'h00; bus.iRs1 = 32'd1; bus.iRs2 = 32'd2; bus.iValid = 1'b1;
    tick();
    bus.iValid = 1'b0;
    bus.iStall = 1'b1;
    check("alu_out", bus.oResult, 32'd3);
    tick();
    check("hold_valid", {31'd0, bus.oValid}, 32'd1);
    check("hold_res", bus.oResult, 32'd3);
    bus.iFlush = 1'b1;
    tick();
    bus.iFlush = 1'b0;
    bus.iStall = 1'b0;
    check("flush_over_stall", {31'd0, bus.oValid}, 32'd0);
    check("flush_res", bus.oResult, 32'd0);

    // Flush and then reset in the middle of a DIVU.
    for (int k = 0; k < 2; k++) begin
      bus.iFunc3 = 3'd5; bus.iFunc7 = 7'h01; bus.iRs1 = 32'd100; bus.iRs2 = 32'd7;
      bus.iValid = 1'b1;
      #1;
      repeat (10) tick();
      bus.iValid = 1'b0;
      if (k == 0) bus.iFlush = 1'b1;
      else        nrst = 1'b0;
      tick();
      bus.iFlush = 1'b0;
      nrst = 1'b1;
      check("abort_valid", {31'd0, bus.oValid}, 32'd0);
      check("abort_busy", {31'd0, bus.oBusy}, 32'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (bus.oValid) seen++;
      end
      check("abort_no_pulse", seen, 32'd0);
      do_op("after_abort", 3'd0, 7'h00, 1'b0, 32'd0, 32'd1, 32'd1, 2'b00, 2'b00, 32'd2, 32'd1, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Parametrised execute stage. Keeps the single-cycle ALU path and adds an iterative RV32M multiply/divide unit with a stall handshake.
- Generalised in three ways: data width, number of forwarding sources, and multiply/divide bits retired per cycle.
- Sits between the ID/EX and EX/MEM pipeline registers and owns the EX/MEM output register.
- Raises a busy/stall request upstream while a multi-cycle op is in flight.

Parameters:
- XLEN, 32: datapath width.
- NFWD, 2: number of forwarding sources; index 0 has the highest priority.
- STEPS, 1: multiply/divide iteration bits per cycle; legal values 1, 2, 4, and XLEN mod STEPS == 0.

Ports:
- iClk  in  1  clock, rising edge.
- nRst  in  1  reset; synchronous, active-low.
- iStall  in  1  downstream hold; output register keeps its value.
- iFlush  in  1  kill the in-flight op and insert a bubble.
- iValid  in  1  instruction present at the input.
- iFunc3  in  3  operation select.
- iFunc7  in  7  operation modifier; 7'b0000001 = M-extension.
- iImmEn  in  1  operand B = immediate.
- iImm  in  XLEN  immediate.
- iRs1, iRs2  in  XLEN  register-file operands.
- iRdAddr  in  5  destination register.
- iFwS1Sel, iFwS2Sel  in  NFWD  forward-enable per source, for S1 and S2.
- iFwData  in  NFWD*XLEN  forward values; slot k = bits [k*XLEN +: XLEN].
- oValid  out  1  EX/MEM entry valid.
- oRdAddr  out  5  destination register.
- oResult  out  XLEN  ALU or muldiv result.
- oStore  out  XLEN  forwarded rs2, used as store data.
- oFunc3  out  3  func3 passed to MEM.
- oBusy  out  1  combinational stall request to IF/ID.

Behaviour:
- Operand A: lowest-index set bit of iFwS1Sel selects that iFwData slot; if no bit is set, iRs1.
- Operand B: iImm if iImmEn; else the iFwS2Sel priority pick; else iRs2.
- oStore always takes the forwarded/raw rs2 value, never the immediate.
- M-op = iValid & iFunc7==7'b0000001 & !iImmEn. All other valid ops go through the single-cycle ALU.
- func3 encoding for M-ops:
  - 0 MUL: low word, signed.
  - 1 MULH: high word, signed×signed.
  - 2 MULHSU: high word, rs1 signed × rs2 unsigned.
  - 3 MULHU: high word, unsigned×unsigned.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Multiply/divide arithmetic:
  - Take magnitudes of the signed operands.
  - Unsigned shift-add multiply into a 2*XLEN product, or restoring divide, STEPS bits per cycle.
  - Negate at the end: product if operand signs differ; quotient if signs differ; remainder takes the dividend's sign.
- FSM states IDLE, BUSY, DONE:
  - IDLE → BUSY when an M-op is presented. Operands and control are captured and the counter is loaded with XLEN/STEPS.
  - BUSY decrements the counter once per cycle; at 0 → DONE.
  - DONE → IDLE on the first edge with !iStall. The result is written to the output register on that same edge.
- Divide special cases skip BUSY and go straight IDLE → DONE:
  - Divide-by-zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- oBusy = (state==IDLE & M-op presented) | state==BUSY | (state==DONE & iStall). Upstream holds its instruction while oBusy is high.
- Latency from first presentation to oValid high:
  - ALU op: 1 edge.
  - M-op: XLEN/STEPS + 2 edges.
  - Special divide case: 2 edges.
  - Extended by any iStall cycles.
- Output register, evaluated in priority order each edge:
  - !nRst or iFlush: all outputs = 0 and the FSM goes to IDLE. Reset or flush mid-op abandons the op; no partial result is emitted.
  - Else iStall: hold.
  - Else FSM not finishing (IDLE with M-op, or BUSY): load a bubble (oValid=0).
  - Else: load result, rd, func3 and store data; oValid = the captured iValid.
- iFlush and iStall asserted together: flush wins.
- Each M-op produces exactly one oValid pulse.
- Inputs are ignored while in BUSY/DONE. The captured copies are used, so forwarding changes mid-op have no effect.
- Reset value of every output is 0; FSM resets to IDLE.

Test Plan:
- ADD, iRs1=5, iFwS1Sel=01, slot0=100, iRs2=7 → oResult=107, oValid=1 after 1 edge; oBusy stays 0.
- MUL rs1=-3, rs2=7 (XLEN=32, STEPS=1) → oResult=0xFFFFFFEB after 34 edges; MULH → 0xFFFFFFFF. oBusy high 33 cycles, single oValid pulse, bubbles before it.
- DIV 7/0 → 0xFFFFFFFF; REMU 7/0 → 7; each with 2-edge latency.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Also REM -7/2 → -1 and DIV -7/2 → -3.
- iStall high for 3 cycles while in DONE → output register held, oBusy high; result loads once on the first !iStall edge.
- iFlush (then separately nRst=0) at cycle 10 of a DIVU → next edge oValid=0, oBusy=0, FSM IDLE; a following ADD 1+1 → oResult=2 after 1 edge.
